shift_sequencer: RTL and testbench

- Multi-step sequencer for the combinational 1-bit left/right shifter.
- Loads an N-bit word, then applies one single-bit shift per clock for a requested number of steps, using the same left/right encoding as the shifter. It then presents the result with a one-cycle done pulse.
- Upstream side: start/ready command handshake. Downstream side: result register plus per-cycle l/r control strobes for observation.

---
 rtl/shift_sequencer.sv | 60 ++++++
 tb/tb_shift_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: loads a word and applies count single-bit left/right shifts or rotates, then pulses done
module shift_sequencer #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  input  logic [N-1:0]  data,
  input  logic          dir,
  input  logic [CW-1:0] count,
  input  logic          rot,
  input  logic          fill,
  output logic [N-1:0]  q,
  output logic          done,
  output logic          l,
  output logic          r
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d, rot_q, rot_d, fill_q, fill_d, accept;
  always_comb begin
    accept  = state_q == IDLE && start;
    shifted = dir_q ? {rot_q ? q_q[0] : fill_q, q_q[N-1:1]}
                    : {q_q[N-2:0], rot_q ? q_q[N-1] : fill_q};
    q_d     = accept ? data : state_q == RUN ? shifted : q_q;
    cnt_d   = accept ? count : state_q == RUN ? cnt_q - CW'(1) : cnt_q;
    dir_d   = accept ? dir : dir_q;
    rot_d   = accept ? rot : rot_q;
    fill_d  = accept ? fill : fill_q;
    state_d = state_q == IDLE ? (!start ? IDLE : count != '0 ? RUN : DONE)
            : state_q == RUN  ? (cnt_q == CW'(1) ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      fill_q  <= fill_d;
    end
  end
  assign ready = state_q == IDLE;
  assign done  = state_q == DONE;
  assign l     = state_q == RUN && !dir_q;
  assign r     = state_q == RUN && dir_q;
  assign q     = q_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against a step-list model
module tb_shift_sequencer;
  localparam int N  = 4;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready, done, l, r;
  logic [N-1:0]  data = '0;
  logic          dir = 1'b0, rot = 1'b0, fill = 1'b0;
  logic [CW-1:0] count = '0;
  logic [N-1:0]  q;
  int checks = 0;
  int failures = 0;
  shift_sequencer #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .data(data), .dir(dir),
    .count(count), .rot(rot), .fill(fill), .q(q), .done(done), .l(l), .r(r)
  );
  always #5 clk = ~clk;
  function automatic logic [N-1:0] step(input logic [N-1:0] v, input logic dr, input logic rt, input logic f);
    int x, b, m;
    x = int'(v);
    m = (1 << N) - 1;
    if (!dr) begin
      b = rt ? (x >> (N - 1)) & 1 : int'(f);
      return N'(((x << 1) | b) & m);
    end
    b = rt ? x & 1 : int'(f);
    return N'((x >> 1) | (b << (N - 1)));
  endfunction
  task automatic run_cmd(input logic [N-1:0] d, input logic dr, input logic [CW-1:0] c,
                         input logic rt, input logic f, input bit inj, input bit chk_fin,
                         input logic [N-1:0] fin);
    logic [N-1:0] e [0:(1<<CW)-1];
    int w = 0;
    int k = int'(c);
    e[0] = d;
    for (int i = 1; i <= k; i++) e[i] = step(e[i-1], dr, rt, f);
    while (ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait got=%b want=1", ready);
    end
    data = d; dir = dr; count = c; rot = rt; fill = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data = N'($urandom); dir = 1'($urandom); count = CW'($urandom); rot = 1'($urandom); fill = 1'($urandom);
    for (int i = 0; i < k; i++) begin
      checks++;
      if ({l, r} !== {~dr, dr}) begin
        failures++;
        $display("FAIL run_lr step=%0d got=%b%b want=%b%b", i, l, r, ~dr, dr);
      end
      checks++;
      if (q !== e[i]) begin
        failures++;
        $display("FAIL run_q step=%0d got=%b want=%b", i, q, e[i]);
      end
      checks++;
      if ({ready, done} !== 2'b00) begin
        failures++;
        $display("FAIL run_ready_done step=%0d got=%b%b want=00", i, ready, done);
      end
      if (inj) begin
        start = 1'b1;
        data = 4'b0101;
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({done, ready, l, r} !== 4'b1000) begin
      failures++;
      $display("FAIL done_flags got done=%b ready=%b l=%b r=%b want 1000", done, ready, l, r);
    end
    checks++;
    if (q !== e[k]) begin
      failures++;
      $display("FAIL done_q got=%b want=%b", q, e[k]);
    end
    if (chk_fin) begin
      checks++;
      if (q !== fin) begin
        failures++;
        $display("FAIL final_const got=%b want=%b", q, fin);
      end
    end
    if (inj) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({ready, done, l, r} !== 4'b1000 || q !== e[k]) begin
      failures++;
      $display("FAIL post_done got ready=%b done=%b l=%b r=%b q=%b want 1000 q=%b", ready, done, l, r, q, e[k]);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({ready, done, l, r, q} !== {4'b1000, N'(0)}) begin
      failures++;
      $display("FAIL reset got ready=%b done=%b l=%b r=%b q=%b want 1000 q=0000", ready, done, l, r, q);
    end
  endtask
  task automatic test_plan();
    run_cmd(4'b1011, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    run_cmd(4'b1011, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110);
    run_cmd(4'b1001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1001);
    run_cmd(4'b0000, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1110);
    run_cmd(4'b1111, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    run_cmd(4'b0110, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100);
  endtask
  task automatic test_start_ignored();
    run_cmd(4'b1100, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001);
  endtask
  task automatic test_reset_mid_run();
    data = 4'b1011; dir = 1'b0; count = 4'd4; rot = 1'b1; fill = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, done, l, r, q} !== {4'b1000, N'(0)}) begin
      failures++;
      $display("FAIL reset_mid_run got ready=%b done=%b l=%b r=%b q=%b want 1000 q=0000", ready, done, l, r, q);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ready, done} !== 2'b10) begin
      failures++;
      $display("FAIL reset_no_done got ready=%b done=%b want 10", ready, done);
    end
    run_cmd(4'b0011, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1100);
  endtask
  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_cmd(N'($urandom), 1'($urandom), CW'($urandom_range(0, (1 << CW) - 1)), 1'($urandom),
              1'($urandom), bit'($urandom_range(0, 3) == 0), 1'b0, '0);
  endtask
  task automatic test_back_to_back();
    run_cmd(4'b1000, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111);
    run_cmd(4'b0001, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
    run_cmd(4'b0101, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0101);
  endtask
  initial begin
    test_reset();
    test_plan();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
